// File: rtl/seq_restoring_divider_pkg.sv
// Shared arithmetic types and helpers for the DCT quantiser divider family.
// Imported by the divider interface, the step datapath and the divider top.
package dct_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int DIV_W_DEFAULT = 8;

  // Bits needed to count down from n-1 to 0; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for the sequential divider: in_* from producer, out_* to consumer.
// The master modport is the producer/consumer side, slave is the divider.
interface seq_restoring_divider_if
  import dct_arith_pkg::*;
#(
  parameter int N = DIV_W_DEFAULT
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational radix-2 restoring step: shift in the next dividend bit, trial-subtract, restore.
// Zero latency; kept separate so an unrolled or pipelined divider can reuse it.
module div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] r_o,
  output logic [N-1:0] q_o
);

  logic [N:0] r_sh;
  logic [N:0] diff;
  logic       ge;

  always_comb begin
    r_sh = {r_i, q_i[N-1]};
    diff = r_sh - {1'b0, divisor_i};
    // r_i < divisor_i keeps r_sh below 2*divisor, so the top bit of diff is exactly the borrow.
    ge   = ~diff[N];
    r_o  = ge ? diff[N-1:0] : r_sh[N-1:0];
    q_o  = {q_i[N-2:0], ge};
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned N-bit restoring divider, one quotient bit per clock; result N+1 cycles after accept (1 for /0).
// One division in flight: in_ready only in IDLE, result held in DONE until out_ready.
module seq_restoring_divider
  import dct_arith_pkg::*;
#(
  parameter int N = DIV_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CNT_W = clog2(N);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     r_q, r_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic             dbz_q, dbz_d;

  logic [N-1:0]     step_r;
  logic [N-1:0]     step_q;

  div_step #(
    .N(N)
  ) u_step (
    .r_i      (r_q),
    .q_i      (q_q),
    .divisor_i(dvs_q),
    .r_o      (step_r),
    .q_o      (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvs_d = bus.divisor;
          cnt_d = CNT_W'(N - 1);
          if (bus.divisor == '0) begin
            // Divide-by-zero skips the iteration and reports all-ones with the dividend as remainder.
            q_d     = '1;
            r_d     = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = bus.dividend;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        q_d = step_q;
        r_d = step_r;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed vectors with hand-computed results,
// then random operand pairs with random input delays and output stalls.
module tb_seq_restoring_divider;
  import dct_arith_pkg::*;

  localparam int N = DIV_W_DEFAULT;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           acc_cyc;
    int           lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  logic prev_vld = 1'b0;
  logic rel_chk  = 1'b0;

  seq_restoring_divider_if #(.N(N)) ifc ();

  seq_restoring_divider #(
    .N(N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
      rel_chk  = 1'b0;
    end else begin
      if (rel_chk) begin
        chk("release_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("release_out_valid", 32'(ifc.out_valid), 32'd0);
        rel_chk = 1'b0;
      end
      if (ifc.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(ifc.out_valid), 32'd0);
        end else begin
          if (!prev_vld) begin
            chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
          end
          chk("quotient", 32'(ifc.quotient), 32'(sb[0].q));
          chk("remainder", 32'(ifc.remainder), 32'(sb[0].r));
          chk("div_by_zero", 32'(ifc.div_by_zero), 32'(sb[0].dbz));
          chk("busy_in_ready", 32'(ifc.in_ready), 32'd0);
          if (ifc.out_ready) begin
            void'(sb.pop_front());
            rel_chk = 1'b1;
          end
        end
      end
      prev_vld = ifc.out_valid;
    end
  end

  // Issue one division and wait for its result to be released; returns at posedge+1.
  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] q_exp, input logic [N-1:0] r_exp,
                        input logic dbz_exp, input int in_dly, input int out_stall);
    int   n;
    exp_t e;
    ifc.out_ready = (out_stall == 0);
    repeat (in_dly) begin
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b1;
    ifc.dividend = a;
    ifc.divisor  = b;
    n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!ifc.in_ready) begin
      chk("accept_timeout", 32'(ifc.in_ready), 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    e.q       = q_exp;
    e.r       = r_exp;
    e.dbz     = dbz_exp;
    e.acc_cyc = cyc;
    e.lat     = (b == '0) ? 1 : N + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.dividend = N'($urandom);
    ifc.divisor  = N'($urandom);
    n = 0;
    @(negedge clk);
    while (!ifc.out_valid && n < 2 * N + 8) begin
      n++;
      @(negedge clk);
    end
    if (!ifc.out_valid) begin
      chk("result_timeout", 32'(ifc.out_valid), 32'd1);
      sb.delete();
      return;
    end
    if (out_stall > 0) begin
      repeat (out_stall) @(posedge clk);
      #1;
      ifc.out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] a, b, q, r;
    logic         z;
    int           n;

    ifc.in_valid  = 1'b0;
    ifc.dividend  = '0;
    ifc.divisor   = '0;
    ifc.out_ready = 1'b0;

    #12;
    chk("reset_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("reset_quotient", 32'(ifc.quotient), 32'd0);
    chk("reset_remainder", 32'(ifc.remainder), 32'd0);
    chk("reset_div_by_zero", 32'(ifc.div_by_zero), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_div(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 0, 0);
    do_div(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 0, 0);
    do_div(8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 0, 0);
    do_div(8'd5,   8'd200, 8'd0,   8'd5,  1'b0, 1, 0);
    do_div(8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 0, 0);
    do_div(8'd200, 8'd9,   8'd22,  8'd2,  1'b0, 0, 5);

    // Reset during the 4th RUN cycle of 100/3 discards the division.
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.dividend  = 8'd100;
    ifc.divisor   = 8'd3;
    n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("mid_reset_accept", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("mid_reset_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("mid_reset_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("mid_reset_quotient", 32'(ifc.quotient), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_div(8'd50, 8'd4, 8'd12, 8'd2, 1'b0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      a = N'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom_range(1, 255));
      if (b == '0) begin
        q = '1;
        r = a;
        z = 1'b1;
      end else begin
        q = a / b;
        r = a % b;
        z = 1'b0;
      end
      do_div(a, b, q, r, z, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
